// File: rtl/nubus_mem_arbiter_if.sv
// Bus bundle for nubus_mem_arbiter: two requester ports (A, B) plus the shared memory side.
// master = requesters and memory (the environment); slave = the arbiter itself.
interface nubus_mem_arbiter_if;
    logic        a_valid;
    logic [3:0]  a_write;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_ready;
    logic [31:0] a_rdata;
    logic        a_err;

    logic        b_valid;
    logic [3:0]  b_write;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_ready;
    logic [31:0] b_rdata;
    logic        b_err;

    logic        mem_valid_o;
    logic [3:0]  mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  mem_wait_clocks_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic [1:0]  grant_o;

    modport master (
        output a_valid, a_write, a_addr, a_wdata,
        input  a_ready, a_rdata, a_err,
        output b_valid, b_write, b_addr, b_wdata,
        input  b_ready, b_rdata, b_err,
        input  mem_valid_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wait_clocks_o,
        output mem_rdata_i, mem_ready_i,
        input  grant_o
    );

    modport slave (
        input  a_valid, a_write, a_addr, a_wdata,
        output a_ready, a_rdata, a_err,
        input  b_valid, b_write, b_addr, b_wdata,
        output b_ready, b_rdata, b_err,
        output mem_valid_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wait_clocks_o,
        input  mem_rdata_i, mem_ready_i,
        output grant_o
    );
endinterface

// File: rtl/nubus_mem_arbiter.sv
// Two-port memory arbiter: alternating priority on contention, registered memory strobe,
// per-port wait-clock code, and a granted-cycle timeout that aborts with an error flag.
module nubus_mem_arbiter #(
    parameter int unsigned WAIT_A         = 2,
    parameter int unsigned WAIT_B         = 0,
    parameter int unsigned TIMEOUT_CLOCKS = 15
) (
    input  logic               mem_clk,
    input  logic               mem_reset,
    nubus_mem_arbiter_if.slave bus
);
    // Encoding doubles as the one-hot {B,A} grant vector.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CLOCKS - 1);

    state_t      state_q, state_d;
    logic        last_grant_b_q;
    logic [7:0]  tmo_q;
    logic [3:0]  mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  mem_wait_q;

    logic        capture_a, capture_b;
    logic        xfer_done;
    logic        a_ready, a_err, b_ready, b_err;
    logic [31:0] a_rdata, b_rdata;

    always_comb begin
        state_d   = state_q;
        capture_a = 1'b0;
        capture_b = 1'b0;
        a_ready   = 1'b0;
        a_err     = 1'b0;
        b_ready   = 1'b0;
        b_err     = 1'b0;
        a_rdata   = '0;
        b_rdata   = '0;
        xfer_done = bus.mem_ready_i || (tmo_q == TMO_LAST);
        unique case (state_q)
            IDLE: begin
                if (bus.a_valid && (!bus.b_valid || last_grant_b_q)) begin
                    state_d   = GNT_A;
                    capture_a = 1'b1;
                end else if (bus.b_valid) begin
                    state_d   = GNT_B;
                    capture_b = 1'b1;
                end
            end
            GNT_A: begin
                a_rdata = bus.mem_rdata_i;
                if (xfer_done) begin
                    state_d = IDLE;
                    // A reset in the completion cycle abandons the transfer silently.
                    a_ready = !mem_reset;
                    a_err   = !mem_reset && !bus.mem_ready_i;
                end
            end
            GNT_B: begin
                b_rdata = bus.mem_rdata_i;
                if (xfer_done) begin
                    state_d = IDLE;
                    b_ready = !mem_reset;
                    b_err   = !mem_reset && !bus.mem_ready_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            state_q        <= IDLE;
            last_grant_b_q <= 1'b1;
            tmo_q          <= '0;
            mem_write_q    <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wait_q     <= '0;
        end else begin
            state_q <= state_d;
            if (capture_a) begin
                mem_write_q    <= bus.a_write;
                mem_addr_q     <= bus.a_addr;
                mem_wdata_q    <= bus.a_wdata;
                mem_wait_q     <= 2'(WAIT_A);
                last_grant_b_q <= 1'b0;
                tmo_q          <= '0;
            end else if (capture_b) begin
                mem_write_q    <= bus.b_write;
                mem_addr_q     <= bus.b_addr;
                mem_wdata_q    <= bus.b_wdata;
                mem_wait_q     <= 2'(WAIT_B);
                last_grant_b_q <= 1'b1;
                tmo_q          <= '0;
            end else if (state_q != IDLE) begin
                tmo_q <= tmo_q + 8'd1;
            end
        end
    end

    assign bus.mem_valid_o       = (state_q != IDLE);
    assign bus.grant_o           = state_q;
    assign bus.mem_write_o       = mem_write_q;
    assign bus.mem_addr_o        = mem_addr_q;
    assign bus.mem_wdata_o       = mem_wdata_q;
    assign bus.mem_wait_clocks_o = mem_wait_q;
    assign bus.a_ready           = a_ready;
    assign bus.a_err             = a_err;
    assign bus.a_rdata           = a_rdata;
    assign bus.b_ready           = b_ready;
    assign bus.b_err             = b_err;
    assign bus.b_rdata           = b_rdata;
endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Bench for nubus_mem_arbiter: queued requesters, a behavioural memory, a transaction-level
// reference model compared every cycle, and literal timing/data expectations per scenario.
module tb_nubus_mem_arbiter;
    localparam int unsigned WAIT_A = 2;
    localparam int unsigned WAIT_B = 0;
    localparam int unsigned TMO    = 15;
    localparam int LOGN = 1024;

    logic mem_clk = 1'b0;
    logic mem_reset = 1'b1;
    always #5 mem_clk = ~mem_clk;

    nubus_mem_arbiter_if bus();

    nubus_mem_arbiter #(
        .WAIT_A(WAIT_A),
        .WAIT_B(WAIT_B),
        .TIMEOUT_CLOCKS(TMO)
    ) dut (
        .mem_clk(mem_clk),
        .mem_reset(mem_reset),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          drop;
    } txn_t;

    txn_t aq[$];
    txn_t bq[$];
    bit   a_dropped, b_dropped;

    logic [31:0] mem [logic [31:0]];
    int   mem_ready_at = -1;
    bit   idle_noise   = 1'b0;
    int   mem_cnt      = 0;

    // Reference model: who owns the bus, how long, and what was captured.
    int          owner = 0;      // 0 none, 1 A, 2 B
    int          age   = 0;      // granted cycles already elapsed without completion
    int          last_owner = 2;
    logic [3:0]  m_wr    = '0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [1:0]  m_wait  = '0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic        valid_log [LOGN];
    logic [1:0]  grant_log [LOGN];
    logic        ar_log    [LOGN];
    logic        ae_log    [LOGN];
    logic        br_log    [LOGN];
    logic        be_log    [LOGN];
    logic [31:0] ard_log   [LOGN];
    logic [31:0] brd_log   [LOGN];
    logic [3:0]  mw_log    [LOGN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic drive_req();
        bus.a_valid = (aq.size() > 0) && !a_dropped;
        bus.a_write = (aq.size() > 0) ? aq[0].wr    : 4'h0;
        bus.a_addr  = (aq.size() > 0) ? aq[0].addr  : 32'h0;
        bus.a_wdata = (aq.size() > 0) ? aq[0].wdata : 32'h0;
        bus.b_valid = (bq.size() > 0) && !b_dropped;
        bus.b_write = (bq.size() > 0) ? bq[0].wr    : 4'h0;
        bus.b_addr  = (bq.size() > 0) ? bq[0].addr  : 32'h0;
        bus.b_wdata = (bq.size() > 0) ? bq[0].wdata : 32'h0;
    endtask

    task automatic cycle();
        logic [31:0] rd, w;
        logic [1:0]  eg;
        logic        mr;
        bit          done, last_slot;
        drive_req();
        @(negedge mem_clk);
        if (bus.mem_valid_o) begin
            rd = mem_word(bus.mem_addr_o);
            for (int unsigned i = 0; i < 4; i++)
                if (bus.mem_write_o[i]) rd[i*8 +: 8] = 8'hzz;
            bus.mem_rdata_i = rd;
            bus.mem_ready_i = (mem_ready_at >= 0) ? (mem_cnt == mem_ready_at)
                                                  : (mem_cnt == int'(bus.mem_wait_clocks_o));
        end else begin
            bus.mem_rdata_i = 32'hDEAD_BEEF;
            bus.mem_ready_i = idle_noise;
        end
        #1;
        mr        = bus.mem_ready_i;
        last_slot = (owner != 0) && (age + 1 == int'(TMO));
        done      = (owner != 0) && (mr || last_slot) && !mem_reset;
        eg        = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;

        chk("mem_valid", bus.mem_valid_o, owner != 0);
        chk("grant", bus.grant_o, eg);
        chk("mem_write", bus.mem_write_o, m_wr);
        chk("mem_addr", bus.mem_addr_o, m_addr);
        chk("mem_wdata", bus.mem_wdata_o, m_wdata);
        chk("mem_wait", bus.mem_wait_clocks_o, m_wait);
        chk("a_ready", bus.a_ready, done && owner == 1);
        chk("a_err", bus.a_err, done && owner == 1 && !mr);
        chk("b_ready", bus.b_ready, done && owner == 2);
        chk("b_err", bus.b_err, done && owner == 2 && !mr);
        chk("a_rdata", bus.a_rdata, (owner == 1) ? bus.mem_rdata_i : 32'h0);
        chk("b_rdata", bus.b_rdata, (owner == 2) ? bus.mem_rdata_i : 32'h0);

        if (cyc < LOGN) begin
            valid_log[cyc] = bus.mem_valid_o;
            grant_log[cyc] = bus.grant_o;
            ar_log[cyc]    = bus.a_ready;
            ae_log[cyc]    = bus.a_err;
            br_log[cyc]    = bus.b_ready;
            be_log[cyc]    = bus.b_err;
            ard_log[cyc]   = bus.a_rdata;
            brd_log[cyc]   = bus.b_rdata;
            mw_log[cyc]    = bus.mem_write_o;
        end

        // memory side effects
        if (bus.mem_valid_o && mr) begin
            w = mem_word(bus.mem_addr_o);
            for (int unsigned i = 0; i < 4; i++)
                if (bus.mem_write_o[i]) w[i*8 +: 8] = bus.mem_wdata_o[i*8 +: 8];
            mem[bus.mem_addr_o] = w;
        end
        mem_cnt = (bus.mem_valid_o && !mr) ? mem_cnt + 1 : 0;

        // model advance
        if (mem_reset) begin
            owner = 0; age = 0; last_owner = 2;
            m_wr = '0; m_addr = '0; m_wdata = '0; m_wait = '0;
            a_dropped = 0; b_dropped = 0;
        end else if (owner == 0) begin
            if (bus.a_valid && (!bus.b_valid || last_owner == 2)) begin
                owner = 1; last_owner = 1; age = 0;
                m_wr = bus.a_write; m_addr = bus.a_addr; m_wdata = bus.a_wdata; m_wait = 2'(WAIT_A);
                a_dropped = aq[0].drop;
            end else if (bus.b_valid) begin
                owner = 2; last_owner = 2; age = 0;
                m_wr = bus.b_write; m_addr = bus.b_addr; m_wdata = bus.b_wdata; m_wait = 2'(WAIT_B);
                b_dropped = bq[0].drop;
            end
        end else if (done) begin
            if (owner == 1) begin void'(aq.pop_front()); a_dropped = 0; end
            else            begin void'(bq.pop_front()); b_dropped = 0; end
            owner = 0;
        end else begin
            age++;
        end

        @(posedge mem_clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((aq.size() > 0 || bq.size() > 0 || owner != 0) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (aq.size() > 0 || bq.size() > 0 || owner != 0) begin
            errors++;
            $display("FAIL run_budget cyc=%0d actual=busy required=idle within %0d cycles", cyc, budget);
            aq.delete(); bq.delete();
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, bus.mem_valid_o, 1'b0);
        chk({tag, "_grant"}, bus.grant_o, 2'b00);
        chk({tag, "_write"}, bus.mem_write_o, 4'h0);
        chk({tag, "_addr"},  bus.mem_addr_o, 32'h0);
        chk({tag, "_wdata"}, bus.mem_wdata_o, 32'h0);
        chk({tag, "_wait"},  bus.mem_wait_clocks_o, 2'b00);
    endtask

    initial begin
        int t0, t1;
        bus.mem_rdata_i = 32'h0;
        bus.mem_ready_i = 1'b0;
        drive_req();
        mem[32'h10] = 32'hCAFE_F00D;
        mem[32'h20] = 32'h1122_3344;

        mem_reset = 1'b1;
        cycle();
        cycle();
        mem_reset = 1'b0;
        chk_reset_values("por");

        // memory acknowledges while idle must be ignored
        idle_noise = 1'b1;
        repeat (3) cycle();

        // single read on A with two wait clocks
        t0 = cyc;
        aq.push_back('{4'h0, 32'h10, 32'h0, 1'b0});
        run_until_idle(40);
        cycle();
        chk("rd_valid_c0", valid_log[t0], 1'b0);
        chk("rd_valid_c1", valid_log[t0+1], 1'b1);
        chk("rd_valid_c3", valid_log[t0+3], 1'b1);
        chk("rd_ready_c2", ar_log[t0+2], 1'b0);
        chk("rd_ready_c3", ar_log[t0+3], 1'b1);
        chk("rd_data", ard_log[t0+3], 32'hCAFE_F00D);
        chk("rd_idle_c4", valid_log[t0+4], 1'b0);

        // byte write on B, zero wait, then read back through A
        t0 = cyc;
        bq.push_back('{4'b0010, 32'h20, 32'h0000_AB00, 1'b0});
        run_until_idle(40);
        chk("wr_strobe", mw_log[t0+1], 4'b0010);
        chk("wr_ready", br_log[t0+1], 1'b1);
        chk("wr_err", be_log[t0+1], 1'b0);
        t1 = cyc;
        aq.push_back('{4'h0, 32'h20, 32'h0, 1'b0});
        run_until_idle(40);
        chk("wr_readback", ard_log[t1+3], 32'h1122_AB44);
        idle_noise = 1'b0;

        // timeout: memory never answers
        mem_ready_at = 1000;
        t0 = cyc;
        aq.push_back('{4'h0, 32'h10, 32'h0, 1'b0});
        run_until_idle(40);
        mem_ready_at = -1;
        cycle();
        chk("tmo_ready_c14", ar_log[t0+14], 1'b0);
        chk("tmo_ready_c15", ar_log[t0+15], 1'b1);
        chk("tmo_err_c15", ae_log[t0+15], 1'b1);
        chk("tmo_idle_c16", valid_log[t0+16], 1'b0);
        t1 = cyc;
        bq.push_back('{4'h0, 32'h10, 32'h0, 1'b0});
        run_until_idle(40);
        chk("tmo_b_ready", br_log[t1+1], 1'b1);
        chk("tmo_b_err", be_log[t1+1], 1'b0);
        chk("tmo_b_data", brd_log[t1+1], 32'hCAFE_F00D);

        // memory answers exactly in the timeout cycle: normal completion
        mem_ready_at = 14;
        t0 = cyc;
        aq.push_back('{4'h0, 32'h10, 32'h0, 1'b0});
        run_until_idle(40);
        mem_ready_at = -1;
        chk("prec_ready", ar_log[t0+15], 1'b1);
        chk("prec_err", ae_log[t0+15], 1'b0);

        // requester withdraws after grant; transfer still completes
        t0 = cyc;
        aq.push_back('{4'h0, 32'h10, 32'h0, 1'b1});
        run_until_idle(40);
        chk("drop_ready", ar_log[t0+3], 1'b1);
        chk("drop_valid", valid_log[t0+3], 1'b1);

        // reset during the second granted cycle of A
        t0 = cyc;
        aq.push_back('{4'h0, 32'h10, 32'h0, 1'b0});
        cycle();
        cycle();
        aq.delete();
        mem_reset = 1'b1;
        cycle();
        mem_reset = 1'b0;
        chk("rst_no_ready", ar_log[t0+2], 1'b0);
        chk("rst_was_granted", valid_log[t0+2], 1'b1);
        chk_reset_values("mid");
        cycle();

        // contention right after reset: strict alternation starting with A
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            aq.push_back('{4'h0, (k % 2 == 0) ? 32'h10 : 32'h20, 32'h0, 1'b0});
            bq.push_back('{4'h0, (k % 2 == 0) ? 32'h20 : 32'h10, 32'h0, 1'b0});
        end
        run_until_idle(100);
        for (int k = 0; k < 4; k++) begin
            chk("cont_grant_a", grant_log[t0+1+6*k], 2'b01);
            chk("cont_gap_a", valid_log[t0+4+6*k], 1'b0);
            chk("cont_grant_b", grant_log[t0+5+6*k], 2'b10);
            chk("cont_gap_b", valid_log[t0+6+6*k], 1'b0);
        end
        chk("cont_last_b", br_log[t0+23], 1'b1);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end
endmodule

// File: doc/nubus_mem_arbiter.md
NUBUS_MEM_ARBITER -- requirements
Module: nubus_mem_arbiter

Interface
REQ-001 Parameter WAIT_A, default 2: wait-clock code driven on mem_wait_clocks_o while port A is granted.
REQ-002 Parameter WAIT_B, default 0: wait-clock code driven on mem_wait_clocks_o while port B is granted.
REQ-003 Parameter TIMEOUT_CLOCKS, default 15 (range 4..255): granted cycles allowed without mem_ready_i before the arbiter aborts.
REQ-004 mem_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 mem_reset  in  1  synchronous, active-high reset.
REQ-006 a_valid  in  1  port A request; held with a_write, a_addr, a_wdata stable until a_ready.
REQ-007 a_write  in  4  port A byte write strobes; 0 = read.
REQ-008 a_addr  in  32  port A byte address.
REQ-009 a_wdata  in  32  port A write data.
REQ-010 a_ready  out  1  port A completion pulse, one cycle.
REQ-011 a_rdata  out  32  port A read data.
REQ-012 a_err  out  1  port A timeout flag, valid with a_ready.
REQ-013 b_valid, b_write, b_addr, b_wdata, b_ready, b_rdata, b_err: port B, widths and meanings identical to REQ-006..REQ-012.
REQ-014 mem_valid_o  out  1  memory cycle strobe.
REQ-015 mem_write_o  out  4  byte strobes to memory.
REQ-016 mem_addr_o  out  32  address to memory.
REQ-017 mem_wdata_o  out  32  write data to memory.
REQ-018 mem_wait_clocks_o  out  2  wait-clock code to memory.
REQ-019 mem_rdata_i  in  32  read data from memory; unwritten lanes valid, written lanes may be Z.
REQ-020 mem_ready_i  in  1  memory acknowledge.
REQ-021 grant_o  out  2  one-hot current owner ({B,A}); 00 when IDLE.

Function
REQ-022 FSM states IDLE, GNT_A, GNT_B; mem_valid_o SHALL be 1 exactly in GNT_A/GNT_B, from a register (no combinational path from inputs).
REQ-023 IDLE: a_valid only -> GNT_A; b_valid only -> GNT_B; both -> port not granted last (last_grant register); neither -> stay IDLE.
REQ-024 On IDLE->GNT_x the arbiter SHALL register x_write, x_addr, x_wdata and WAIT_x into mem_write_o, mem_addr_o, mem_wdata_o, mem_wait_clocks_o and set last_grant = x; latency request-to-mem_valid_o = 1 cycle.
REQ-025 mem_* data outputs SHALL hold their captured values until the next grant capture.
REQ-026 In GNT_x, x_ready = mem_ready_i combinationally, x_err = 0; on mem_ready_i the FSM SHALL return to IDLE next cycle.
REQ-027 Every transaction SHALL be followed by at least one IDLE cycle with mem_valid_o = 0 so the memory's wait-clock pipeline restarts; maximum throughput = one transaction per (2 + wait) cycles.
REQ-028 x_rdata SHALL equal mem_rdata_i when grant_o selects x, else 32'h0; Z lanes pass through unchanged.
REQ-029 An 8-bit timeout counter SHALL clear on grant and increment each GNT cycle without mem_ready_i; when it reaches TIMEOUT_CLOCKS-1 without mem_ready_i, x_ready = 1 and x_err = 1 for that cycle and FSM returns to IDLE.
REQ-030 mem_ready_i in the timeout cycle SHALL take precedence: normal completion, x_err = 0.
REQ-031 The non-granted port's ready and err SHALL be 0; mem_ready_i in IDLE SHALL be ignored.
REQ-032 A requester dropping x_valid before x_ready SHALL not abort a granted transaction; it completes and x_ready still pulses.

Reset
REQ-033 mem_reset SHALL force IDLE, last_grant = B, timeout counter 0, mem_valid_o 0, mem_write_o 0, mem_addr_o 0, mem_wdata_o 0, mem_wait_clocks_o 0, grant_o 00.
REQ-034 Reset mid-transaction SHALL abandon it with no ready pulse; first grant after reset with both ports requesting goes to A.

Verification
REQ-035 Single read: a_valid, a_write=0, a_addr=32'h10, memory data 32'hCAFEF00D, WAIT_A=2 -> mem_valid_o high cycles 1..3, a_ready at cycle 3, a_rdata=32'hCAFEF00D, then 1 IDLE cycle.
REQ-036 Contention: a_valid and b_valid held for 4 transactions each from reset -> grant order A,B,A,B,A,B,A,B with mem_valid_o low one cycle between each.
REQ-037 Byte write: b_write=4'b0010, b_wdata=32'h0000AB00, WAIT_B=0 -> mem_write_o=4'b0010 registered, b_ready same cycle as grant, readback via A shows byte 1 = 8'hAB.
REQ-038 Timeout: mem_ready_i tied 0, TIMEOUT_CLOCKS=15 -> a_ready=a_err=1 on 15th granted cycle, IDLE next, subsequent b request served.
REQ-039 Reset in GNT_A cycle 2 -> no a_ready, mem_valid_o 0 next cycle, all outputs at REQ-033 values.
